seq_alu: RTL and testbench

- Parametrised successor to the combinational 16-bit, 3-bit-select ALU.
- Operand width is set by `WIDTH`. Input and output are registered with valid/ready handshakes, and the block produces Z/C/V flags.
- Adds a multi-cycle shift-add multiply that returns a full double-width product.
- Sits between the register-file read stage and writeback. Backpressure stalls the block without losing the held result.

---
 rtl/alu_pkg.sv | 95 +++++++++
 rtl/mul_shift_add.sv | 50 +++++
 rtl/seq_alu.sv | 97 +++++++++
 tb/tb_seq_alu.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and the single-cycle ALU function for seq_alu.
package alu_pkg;

  // Widest operand the combinational function handles; seq_alu narrows the result to WIDTH.
  localparam int unsigned ALU_MAX_W = 128;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL_BUSY,
    DONE
  } alu_state_e;

  typedef struct packed {
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef struct packed {
    logic [ALU_MAX_W-1:0] res;
    alu_flags_t           flags;
  } alu_comb_t;

  // Operands are treated as w bits wide; MUL is handled elsewhere and returns zero here.
  function automatic alu_comb_t alu_comb(input logic [ALU_MAX_W-1:0] a,
                                         input logic [ALU_MAX_W-1:0] b,
                                         input alu_op_e op,
                                         input int unsigned w);
    logic [ALU_MAX_W-1:0] mask, smask, am, bm, sh, r;
    logic [ALU_MAX_W:0]   t;
    logic                 c, v, sa, sb, sr;
    int unsigned          sbits;
    alu_comb_t            o;
    mask  = {ALU_MAX_W{1'b1}} >> (ALU_MAX_W - w);
    sbits = $clog2(w);
    smask = {ALU_MAX_W{1'b1}} >> (ALU_MAX_W - sbits);
    am    = a & mask;
    bm    = b & mask;
    sh    = bm & smask;
    t     = '0;
    r     = '0;
    c     = 1'b0;
    v     = 1'b0;
    sa    = am[w-1];
    sb    = bm[w-1];
    unique case (op)
      OP_ADD: begin
        t  = {1'b0, am} + {1'b0, bm};
        r  = t[ALU_MAX_W-1:0] & mask;
        c  = t[w];
        sr = r[w-1];
        v  = (sa == sb) && (sr != sa);
      end
      OP_SUB: begin
        t  = {1'b0, am} - {1'b0, bm};
        r  = t[ALU_MAX_W-1:0] & mask;
        c  = am < bm;
        sr = r[w-1];
        v  = (sa != sb) && (sr != sa);
      end
      OP_AND: r = am & bm;
      OP_OR:  r = am | bm;
      OP_XOR: r = am ^ bm;
      // Widening by one bit captures the last bit shifted out; zero when sh is 0.
      OP_SHL: begin
        t = {1'b0, am} << sh;
        r = t[ALU_MAX_W-1:0] & mask;
        c = t[w];
      end
      OP_SHR: begin
        t = {am, 1'b0} >> sh;
        r = t[ALU_MAX_W:1];
        c = t[0];
      end
      OP_MUL: r = '0;
    endcase
    o.res     = r;
    o.flags.z = (r == '0);
    o.flags.c = c;
    o.flags.v = v;
    return o;
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Unsigned shift-add multiplier, one partial product per clock.
module mul_shift_add
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] a_sh;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] step;
  logic [WIDTH-1:0]   b_sh;
  logic [CW-1:0]      count;

  assign step = b_sh[0] ? acc + a_sh : acc;
  assign busy = (count != '0);
  // The final step is exposed combinationally so the product is ready on the count==1 edge.
  assign done = (count == CW'(1));
  assign prod = step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      count <= '0;
    end else if (start) begin
      a_sh  <= {{WIDTH{1'b0}}, a};
      b_sh  <= b;
      acc   <= '0;
      count <= CW'(WIDTH);
    end else if (busy) begin
      acc   <= step;
      a_sh  <= a_sh << 1;
      b_sh  <= b_sh >> 1;
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes, Z/C/V flags and a multi-cycle MUL.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic [WIDTH-1:0] ALU_Out_Hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  alu_state_e         state, state_nx;
  alu_op_e            op_in;
  alu_comb_t          comb_r;
  alu_flags_t         flags_q;
  logic [WIDTH-1:0]   out_q, hi_q;
  logic [2*WIDTH-1:0] mul_prod;
  logic               live, accept, mul_start, mul_done, load_comb, load_mul;
  logic               unused_hi, unused_mul_busy;

  assign op_in     = alu_op_e'(ALU_Sel);
  assign in_ready  = live && ((state == IDLE) || ((state == DONE) && out_ready));
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op_in == OP_MUL);
  assign load_comb = accept && (op_in != OP_MUL);
  assign load_mul  = (state == MUL_BUSY) && mul_done;

  always_comb comb_r = alu_comb(ALU_MAX_W'(A), ALU_MAX_W'(B), op_in, WIDTH);
  assign unused_hi = ^comb_r.res[ALU_MAX_W-1:WIDTH];

  mul_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (A),
    .b     (B),
    .busy  (unused_mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (accept) state_nx = (op_in == OP_MUL) ? MUL_BUSY : DONE;
      MUL_BUSY: if (mul_done) state_nx = DONE;
      DONE: begin
        if (accept)         state_nx = (op_in == OP_MUL) ? MUL_BUSY : DONE;
        else if (out_ready) state_nx = IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      live    <= 1'b0;
      out_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
    end else begin
      state <= state_nx;
      live  <= 1'b1;
      if (load_comb) begin
        out_q   <= comb_r.res[WIDTH-1:0];
        hi_q    <= '0;
        flags_q <= comb_r.flags;
      end else if (load_mul) begin
        out_q     <= mul_prod[WIDTH-1:0];
        hi_q      <= mul_prod[2*WIDTH-1:WIDTH];
        flags_q.z <= (mul_prod[WIDTH-1:0] == '0);
        flags_q.c <= |mul_prod[2*WIDTH-1:WIDTH];
        flags_q.v <= 1'b0;
      end
    end
  end

  assign ALU_Out    = out_q;
  assign ALU_Out_Hi = hi_q;
  assign flag_z     = flags_q.z;
  assign flag_c     = flags_q.c;
  assign flag_v     = flags_q.v;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=16.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] A, B, ALU_Out, ALU_Out_Hi;
  logic [2:0]  ALU_Sel;
  logic        flag_z, flag_c, flag_v;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .ALU_Sel    (ALU_Sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALU_Out    (ALU_Out),
    .ALU_Out_Hi (ALU_Out_Hi),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .flag_v     (flag_v)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one op for a single accept edge, then withdraw in_valid.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] sel);
    A = a; B = b; ALU_Sel = sel; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] a, b, res;
    logic [2:0]  zcv;
  } vec_t;

  vec_t sweep[7];
  vec_t fvec[6];

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    logic        ready_seen;

    sweep[0] = '{3'd0, 16'h0AB0, 16'h01AC, 16'h0C5C, 3'b000};
    sweep[1] = '{3'd1, 16'h0AB0, 16'h01AC, 16'h0904, 3'b000};
    sweep[2] = '{3'd2, 16'h0AB0, 16'h01AC, 16'h00A0, 3'b000};
    sweep[3] = '{3'd3, 16'h0AB0, 16'h01AC, 16'h0BBC, 3'b000};
    sweep[4] = '{3'd4, 16'h0AB0, 16'h01AC, 16'h0B1C, 3'b000};
    sweep[5] = '{3'd5, 16'h0AB0, 16'h01AC, 16'h0000, 3'b110};
    sweep[6] = '{3'd6, 16'h0AB0, 16'h01AC, 16'h0000, 3'b110};

    fvec[0] = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 3'b001};
    fvec[1] = '{3'd1, 16'h0000, 16'h0001, 16'hFFFF, 3'b010};
    fvec[2] = '{3'd4, 16'h1234, 16'h1234, 16'h0000, 3'b100};
    fvec[3] = '{3'd5, 16'h8001, 16'h0001, 16'h0002, 3'b010};
    fvec[4] = '{3'd6, 16'h1234, 16'h0000, 16'h1234, 3'b000};
    fvec[5] = '{3'd5, 16'h8001, 16'h0010, 16'h8001, 3'b000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; ALU_Sel = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
    chk("rst_out",       {16'd0, ALU_Out}, 32'd0);
    chk("rst_hi",        {16'd0, ALU_Out_Hi}, 32'd0);
    chk("rst_flags",     {29'd0, flag_z, flag_c, flag_v}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back sweep: one result per cycle with in_valid held.
    A = 16'h0AB0; B = 16'h01AC; in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ALU_Sel = sweep[i].sel;
      @(negedge clk);
      chk($sformatf("sweep%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("sweep%0d_ready", i), {31'd0, in_ready}, 32'd1);
      chk($sformatf("sweep%0d_out", i),   {16'd0, ALU_Out}, {16'd0, sweep[i].res});
      chk($sformatf("sweep%0d_hi", i),    {16'd0, ALU_Out_Hi}, 32'd0);
      chk($sformatf("sweep%0d_zcv", i),   {29'd0, flag_z, flag_c, flag_v}, {29'd0, sweep[i].zcv});
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("sweep_drain_valid", {31'd0, out_valid}, 32'd0);

    // MUL: 0x0AB0 * 0x01AC = 0x0011DE40.
    do_op(16'h0AB0, 16'h01AC, 3'd7);
    n = 0; ready_seen = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) ready_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("mul_latency",  n, 32'd16);
    chk("mul_no_ready", {31'd0, ready_seen}, 32'd0);
    chk("mul_lo",       {16'd0, ALU_Out}, 32'h0000DE40);
    chk("mul_hi",       {16'd0, ALU_Out_Hi}, 32'h00000011);
    chk("mul_zcv",      {29'd0, flag_z, flag_c, flag_v}, 32'b010);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_op(fvec[i].a, fvec[i].b, fvec[i].sel);
      chk($sformatf("flag%0d_out", i), {16'd0, ALU_Out}, {16'd0, fvec[i].res});
      chk($sformatf("flag%0d_zcv", i), {29'd0, flag_z, flag_c, flag_v}, {29'd0, fvec[i].zcv});
      @(negedge clk);
    end

    // Backpressure: ADD 3+4 held while a SUB 0x10-1 waits.
    out_ready = 1'b0;
    A = 16'h0003; B = 16'h0004; ALU_Sel = 3'd0; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_first_out", {16'd0, ALU_Out}, 32'h7);
    A = 16'h0010; B = 16'h0001; ALU_Sel = 3'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_ready", i), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp%0d_out", i),   {16'd0, ALU_Out}, 32'h7);
      chk($sformatf("bp%0d_zcv", i),   {29'd0, flag_z, flag_c, flag_v}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_release_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_release_out",   {16'd0, ALU_Out}, 32'h000F);
    @(negedge clk);

    // Reset five cycles into a MUL.
    do_op(16'h0003, 16'h0005, 3'd7);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out",   {16'd0, ALU_Out}, 32'd0);
    chk("midrst_hi",    {16'd0, ALU_Out_Hi}, 32'd0);
    chk("midrst_flags", {29'd0, flag_z, flag_c, flag_v}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready",      {31'd0, in_ready}, 32'd1);
    chk("midrst_still_idle", {31'd0, out_valid}, 32'd0);
    do_op(16'h0001, 16'h0002, 3'd0);
    chk("midrst_add_valid", {31'd0, out_valid}, 32'd1);
    chk("midrst_add_out",   {16'd0, ALU_Out}, 32'h3);
    chk("midrst_add_hi",    {16'd0, ALU_Out_Hi}, 32'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
